// File: rtl/acq_pkg.sv
// Shared defaults and sizing helper for the acquisition input FIFO.
package acq_pkg;

    localparam int ACQ_WIDTH = 2;
    localparam int ACQ_DEPTH = 4;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/acq_fifo_mem.sv
// Purpose: DEPTH x WIDTH sample storage, synchronous write, asynchronous read.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none; the caller gates we.
module acq_fifo_mem
    import acq_pkg::*;
#(
    parameter int WIDTH = ACQ_WIDTH,
    parameter int DEPTH = ACQ_DEPTH
) (
    input  logic                     new_clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge new_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/acq_input_fifo.sv
// Purpose: show-ahead sample FIFO with sticky overflow; ACQ_INPUT_DEDUP_EN skips repeats of the last accepted sample.
// Latency: a capture into an empty buffer is visible on rd_data/rd_valid the cycle after the edge.
// Backpressure: none upstream; a sample arriving while full is dropped unless a pop happens the same cycle.
module acq_input_fifo
    import acq_pkg::*;
#(
    parameter int WIDTH = ACQ_WIDTH,
    parameter int DEPTH = ACQ_DEPTH
) (
    input  logic                        new_clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [WIDTH-1:0]            data_in,
    input  logic                        rd_ready,
    input  logic                        clr_ovf,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_rdata;
    logic             pop;
    logic             cand;
    logic             accept;
    logic             drop;

`ifdef ACQ_INPUT_DEDUP_EN
    logic [WIDTH-1:0] last_dat;
    logic             last_vld;

    assign cand = en && !(last_vld && (data_in == last_dat));
`else
    assign cand = en;
`endif

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot the incoming sample needs.
    assign accept   = cand && (!full || pop);
    assign drop     = cand && full && !pop;
    assign rd_data  = empty ? '0 : mem_rdata;

    acq_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .new_clk (new_clk),
        .we      (accept && !reset),
        .waddr   (wr_ptr),
        .wdata   (data_in),
        .raddr   (rd_ptr),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge new_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ACQ_INPUT_DEDUP_EN
    // Only accepted samples update the tracker; drops leave it untouched.
    always_ff @(posedge new_clk) begin
        if (reset) begin
            last_vld <= 1'b0;
            last_dat <= '0;
        end else if (accept) begin
            last_vld <= 1'b1;
            last_dat <= data_in;
        end
    end
`endif

endmodule

// File: tb/tb_acq_input_fifo.sv
// Directed self-checking bench for acq_input_fifo at WIDTH=2, DEPTH=4.
module tb_acq_input_fifo;

    logic       new_clk;
    logic       reset;
    logic       en;
    logic [1:0] data_in;
    logic       rd_ready;
    logic       clr_ovf;
    logic       rd_valid;
    logic [1:0] rd_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    acq_input_fifo #(.WIDTH(2), .DEPTH(4)) dut (
        .new_clk  (new_clk),
        .reset    (reset),
        .en       (en),
        .data_in  (data_in),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial new_clk = 1'b0;
    always #5 new_clk = ~new_clk;

    task automatic step();
        @(posedge new_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] d);
        en = 1'b1;
        data_in = d;
        step();
        en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; data_in = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);

        // Fill 1,2,3,0 without reading
        push(2'd1);
        chk("first_latency_valid", rd_valid, 1);
        chk("first_latency_data", rd_data, 1);
        chk("first_count", count, 1);
        push(2'd2);
        push(2'd3);
        push(2'd0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_head", rd_data, 1);

        // Drop on full, then clear
        en = 1'b1; data_in = 2'd2; rd_ready = 1'b0;
        step();
        en = 1'b0;
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 4);
        chk("drop_head", rd_data, 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_overflow", overflow, 0);

        // Full with simultaneous pop: sample 1 is accepted
        en = 1'b1; data_in = 2'd1; rd_ready = 1'b1;
        step();
        en = 1'b0; rd_ready = 1'b0;
        chk("fullpop_count", count, 4);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_head", rd_data, 2);

        // Drain: expect 2,3,0,1
        rd_ready = 1'b1;
        chk("drain0", rd_data, 2);
        step();
        chk("drain1", rd_data, 3);
        step();
        chk("drain2", rd_data, 0);
        step();
        chk("drain3", rd_data, 1);
        step();
        chk("drained_empty", empty, 1);
        chk("drained_valid", rd_valid, 0);
        chk("drained_data", rd_data, 0);
        chk("drained_count", count, 0);
        // rd_ready while empty must not move anything
        step();
        rd_ready = 1'b0;
        chk("empty_rd_count", count, 0);
        chk("empty_rd_empty", empty, 1);

        // Refill and test set-wins on clr_ovf with a drop
        push(2'd2);
        chk("refill_head", rd_data, 2);
        push(2'd3);
        push(2'd0);
        push(2'd1);
        chk("refill_full", full, 1);
        en = 1'b1; data_in = 2'd2; clr_ovf = 1'b1;
        step();
        en = 1'b0; clr_ovf = 1'b0;
        chk("set_wins_overflow", overflow, 1);
        chk("set_wins_count", count, 4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr2_overflow", overflow, 0);

        // Pop down to two entries, then reset with en=1
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        chk("two_count", count, 2);
        chk("two_head", rd_data, 0);
        reset = 1'b1; en = 1'b1; data_in = 2'd2;
        step();
        reset = 1'b0; en = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_data", rd_data, 0);
        push(2'd3);
        chk("postrst_count", count, 1);
        chk("postrst_data", rd_data, 3);

        reset = 1'b1;
        step();
        reset = 1'b0;
        en = 1'b1;
        data_in = 2'd2; step();
        data_in = 2'd2; step();
        data_in = 2'd2; step();
        data_in = 2'd1; step();
`ifdef ACQ_INPUT_DEDUP_EN
        data_in = 2'd1; step();
        data_in = 2'd2; step();
        en = 1'b0;
        chk("dedup_count", count, 3);
        chk("dedup_overflow", overflow, 0);
        rd_ready = 1'b1;
        chk("dedup0", rd_data, 2);
        step();
        chk("dedup1", rd_data, 1);
        step();
        chk("dedup2", rd_data, 2);
        step();
        rd_ready = 1'b0;
        chk("dedup_empty", empty, 1);
`else
        en = 1'b0;
        chk("nodedup_count", count, 4);
        chk("nodedup_full", full, 1);
        rd_ready = 1'b1;
        chk("nodedup0", rd_data, 2);
        step();
        chk("nodedup1", rd_data, 2);
        step();
        chk("nodedup2", rd_data, 2);
        step();
        chk("nodedup3", rd_data, 1);
        step();
        rd_ready = 1'b0;
        chk("nodedup_empty", empty, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acq_input_fifo.md
ACQ_INPUT_FIFO -- requirements
Module: acq_input_fifo

Interface
REQ-001 Parameters SHALL be exactly the following (name, default, meaning):
- WIDTH, 2, sample width in bits; legal range 1 or greater.
- DEPTH, 4, buffer entries; must be a power of two, 2 or greater.
REQ-002 Ports SHALL be exactly the following (name, direction, width, meaning):
- new_clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- en, in, 1, capture strobe; samples data_in this edge.
- data_in, in, WIDTH, acquisition sample.
- rd_ready, in, 1, consumer accepts the head entry.
- clr_ovf, in, 1, clears the sticky overflow flag.
- rd_valid, out, 1, head entry present.
- rd_data, out, WIDTH, head entry (show-ahead).
- count, out, log2(DEPTH)+1, number of stored entries.
- full, out, 1, count equals DEPTH.
- empty, out, 1, count equals 0.
- overflow, out, 1, sticky flag: a sample was dropped.
REQ-003 The clock SHALL be named new_clk, and reset SHALL be a synchronous, active-high input named reset.

Function
REQ-004 Write: when en=1 and the sample is accepted, data_in SHALL be stored at the write pointer, and the write pointer SHALL advance modulo DEPTH.
REQ-005 Read: a pop SHALL occur when rd_valid=1 and rd_ready=1; the read pointer SHALL then advance modulo DEPTH.
REQ-006 rd_valid SHALL equal !empty.
REQ-007 rd_data SHALL present the head entry combinationally from the stored data, and SHALL be 0 when empty=1.
REQ-008 Latency: a sample captured into an empty buffer at edge N SHALL appear on rd_data/rd_valid after edge N, i.e. in cycle N+1.
REQ-009 count SHALL update as follows:
- +1 on accept only.
- -1 on pop only.
- unchanged on simultaneous accept and pop.
REQ-010 When full=1 and en=1, the sample SHALL be accepted only if a pop occurs in the same cycle; otherwise it SHALL be dropped.
REQ-011 A dropped sample SHALL set overflow=1 at that edge.
REQ-012 When empty=1, rd_ready=1 SHALL have no effect (no pop, no pointer change).
REQ-013 overflow SHALL remain set until clr_ovf=1 or reset.
REQ-014 If clr_ovf=1 and a drop occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-015 full and empty SHALL be derived from registered count, with no extra cycle of delay.
REQ-016 When en=0, stored contents, pointers and count SHALL change only by pops (hold behaviour).

Reset
REQ-017 On a rising new_clk edge with reset=1, the block SHALL set the following, regardless of en, rd_ready and clr_ovf:
- write pointer, read pointer and count to 0.
- overflow to 0.
- the dedup state (REQ-020) to invalid.
REQ-018 Storage contents SHALL NOT be cleared by reset. After reset, outputs SHALL be:
- empty=1, full=0, rd_valid=0, rd_data=0.
REQ-019 A reset asserted mid-operation SHALL discard all buffered samples at that edge. A capture or pop requested in the same cycle SHALL be ignored.

Configuration
REQ-020 When the macro ACQ_INPUT_DEDUP_EN is defined:
- Capture: a sample with en=1 whose value equals the last accepted sample SHALL be silently skipped.
- Skipped samples: no write, no count change, no overflow.
- Last-accepted tracking: a last-accepted register and a valid bit SHALL track the last accepted value.
- After reset: the valid bit SHALL be 0, so the first sample is always considered for capture.
- Dropped samples: a sample dropped on full SHALL NOT update the last-accepted register.
REQ-021 When ACQ_INPUT_DEDUP_EN is undefined, every en=1 sample SHALL be considered for capture, and no dedup registers SHALL exist.

Structure
REQ-022 The shared package acq_pkg SHALL hold:
- the default WIDTH and DEPTH constants.
- a count-width helper function, log2(DEPTH)+1.
REQ-023 Storage SHALL be a sub-module acq_fifo_mem with the following behaviour:
- DEPTH x WIDTH array.
- synchronous write port.
- asynchronous read port.
REQ-024 Pointer, count, flag and dedup logic SHALL reside in acq_input_fifo.

Verification
REQ-025 The bench SHALL cover the following scenarios with WIDTH=2, DEPTH=4:
- Reset, then idle: count=0, empty=1, rd_valid=0, rd_data=0, overflow=0.
- Write 1,2,3,0 (dedup off), rd_ready=0: full=1, count=4. Then drain with rd_ready=1: rd_data sequence 1,2,3,0, then empty=1.
- Full, en=1, data 2, rd_ready=0: sample dropped, overflow=1, count=4. Then clr_ovf=1: overflow=0.
- Full, en=1, data 1, rd_ready=1 in the same cycle: count stays 4, overflow=0, and the sample appears as the last entry drained.
- Two entries buffered, reset pulse with en=1: count=0, empty=1. The next edge with en=1, data 3 gives count=1, rd_data=3.
- ACQ_INPUT_DEDUP_EN defined, en held at 1 with data 2,2,2,1,1,2: stored sequence 2,1,2, count=3.
